// File: rtl/vga_pkg.sv
// Shared widths and the timing-bus layout for the VGA pixel pipeline stages.
package vga_pkg;
    localparam int COLOR_W = 12;
    localparam int CNT_W   = 11;
    localparam int TBUS_W  = 2 * CNT_W + 4;
    localparam logic [COLOR_W-1:0] BLACK = 12'h000;

    typedef struct packed {
        logic [CNT_W-1:0] hcount;
        logic             hsync;
        logic             hblnk;
        logic [CNT_W-1:0] vcount;
        logic             vsync;
        logic             vblnk;
    } tbus_t;
endpackage

// File: rtl/timing_delay.sv
// Fixed-depth shift-register delay line with synchronous reset.
module timing_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    logic [DEPTH-1:0][WIDTH-1:0] sr;

    always_ff @(posedge pclk) begin
        if (rst) begin
            sr <= '0;
        end else begin
            sr[0] <= din;
            for (int i = 1; i < DEPTH; i++)
                sr[i] <= sr[i-1];
        end
    end

    assign dout = sr[DEPTH-1];
endmodule

// File: rtl/draw_sprite.sv
// Overlays a ROM-backed sprite on the pixel stream; two-stage pipeline with
// the timing bus delayed to stay aligned with rgb_out.
module draw_sprite
    import vga_pkg::*;
#(
    parameter int                 SPR_W_LOG2  = 6,
    parameter int                 SPR_H_LOG2  = 6,
    parameter logic [COLOR_W-1:0] TRANSPARENT = 12'hF0F
) (
    input  logic                           pclk,
    input  logic                           rst,
    input  logic [CNT_W-1:0]               hcount_in,
    input  logic                           hsync_in,
    input  logic                           hblnk_in,
    input  logic [CNT_W-1:0]               vcount_in,
    input  logic                           vsync_in,
    input  logic                           vblnk_in,
    input  logic [COLOR_W-1:0]             rgb_in,
    input  logic [CNT_W-1:0]               xpos,
    input  logic [CNT_W-1:0]               ypos,
    output logic [SPR_H_LOG2+SPR_W_LOG2-1:0] rom_addr,
    input  logic [COLOR_W-1:0]             rom_data,
    output logic [CNT_W-1:0]               hcount_out,
    output logic                           hsync_out,
    output logic                           hblnk_out,
    output logic [CNT_W-1:0]               vcount_out,
    output logic                           vsync_out,
    output logic                           vblnk_out,
    output logic [COLOR_W-1:0]             rgb_out
);
    localparam logic [CNT_W:0] SPR_W = (CNT_W+1)'(1 << SPR_W_LOG2);
    localparam logic [CNT_W:0] SPR_H = (CNT_W+1)'(1 << SPR_H_LOG2);

    logic               vblnk_prev, pos_valid;
    logic [CNT_W-1:0]   x_lat, y_lat;

    // Position is only sampled on the vblank rising edge so a frame never tears.
    always_ff @(posedge pclk) begin
        if (rst) begin
            vblnk_prev <= 1'b0;
            pos_valid  <= 1'b0;
            x_lat      <= '0;
            y_lat      <= '0;
        end else begin
            vblnk_prev <= vblnk_in;
            if (vblnk_in && !vblnk_prev) begin
                x_lat     <= xpos;
                y_lat     <= ypos;
                pos_valid <= 1'b1;
            end
        end
    end

    // End bounds are one bit wider so a sprite straddling 2047 does not wrap.
    logic [CNT_W:0]        x_end, y_end;
    logic [SPR_W_LOG2-1:0] col;
    logic [SPR_H_LOG2-1:0] row;
    logic                  hit;

    assign x_end = {1'b0, x_lat} + SPR_W;
    assign y_end = {1'b0, y_lat} + SPR_H;
    assign col   = SPR_W_LOG2'(hcount_in - x_lat);
    assign row   = SPR_H_LOG2'(vcount_in - y_lat);
    assign hit   = pos_valid && !hblnk_in && !vblnk_in
                && (hcount_in >= x_lat) && ({1'b0, hcount_in} < x_end)
                && (vcount_in >= y_lat) && ({1'b0, vcount_in} < y_end);

    logic               hit_d1, blank_d1;
    logic [COLOR_W-1:0] rgb_d1;

    always_ff @(posedge pclk) begin
        if (rst) begin
            rom_addr <= '0;
            hit_d1   <= 1'b0;
            blank_d1 <= 1'b0;
            rgb_out  <= BLACK;
        end else begin
            hit_d1   <= hit;
            blank_d1 <= hblnk_in | vblnk_in;
            if (hit)
                rom_addr <= {row, col};
            if (blank_d1)
                rgb_out <= BLACK;
            else if (hit_d1 && rom_data != TRANSPARENT)
                rgb_out <= rom_data;
            else
                rgb_out <= rgb_d1;
        end
    end

    tbus_t tbus_in, tbus_out;

    assign tbus_in = '{hcount: hcount_in, hsync: hsync_in, hblnk: hblnk_in,
                       vcount: vcount_in, vsync: vsync_in, vblnk: vblnk_in};

    timing_delay #(.WIDTH(TBUS_W), .DEPTH(2)) u_tbus_dly (
        .pclk (pclk),
        .rst  (rst),
        .din  (tbus_in),
        .dout (tbus_out)
    );

    timing_delay #(.WIDTH(COLOR_W), .DEPTH(1)) u_rgb_dly (
        .pclk (pclk),
        .rst  (rst),
        .din  (rgb_in),
        .dout (rgb_d1)
    );

    assign hcount_out = tbus_out.hcount;
    assign hsync_out  = tbus_out.hsync;
    assign hblnk_out  = tbus_out.hblnk;
    assign vcount_out = tbus_out.vcount;
    assign vsync_out  = tbus_out.vsync;
    assign vblnk_out  = tbus_out.vblnk;
endmodule
